// File: rtl/karaoke_audio_pkg.sv
// Shared types and helpers for the karaoke voice path: Q15 PCM sample type,
// its limits, and the saturating narrow used by the CIC and the FIR.
package karaoke_audio_pkg;

  typedef logic signed [15:0] pcm_t;

  localparam pcm_t Q15_MAX = 16'sh7fff;
  localparam pcm_t Q15_MIN = 16'sh8000;

  // Wide input to sat16; callers sign-extend their accumulator into this width.
  localparam int SAT_IN_W = 48;
  typedef logic signed [SAT_IN_W-1:0] sat_in_t;

  localparam sat_in_t SAT_HI = 48'sd32767;
  localparam sat_in_t SAT_LO = -48'sd32768;

  // Width of the warm-up counter that gates the first CIC outputs.
  localparam int WARM_W = 3;

  function automatic pcm_t sat16(input sat_in_t x);
    if (x > SAT_HI) begin
      return Q15_MAX;
    end else if (x < SAT_LO) begin
      return Q15_MIN;
    end
    return pcm_t'(x[15:0]);
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM microphone clock divider, 2-flop data synchronizer and sample strobe.
// The strobe fires in the last clk cycle of each PDM period.
module pdm_clkgen #(
  parameter int PDM_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pdm_data,
  output logic pdm_clk,
  output logic pdm_bit,
  output logic sample_stb
);

  localparam int CNT_W = $clog2(PDM_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PDM_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PDM_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;

  // NOTE: every combinational output gets its default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) cnt_d = '0;
    pdm_clk_d = (cnt_q < CNT_HALF);
    sync1_d   = pdm_data;
    sync2_d   = sync1_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, like real hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  assign pdm_clk    = pdm_clk_q;
  assign pdm_bit    = sync2_q;
  assign sample_stb = (cnt_q == CNT_LAST);

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM front end: N-stage CIC (M = 1) decimating the 1-bit mic stream by
// 2^R_LOG2 into saturated Q15 PCM, with a warm-up gate on the first outputs.
module pdm_cic_decimator
  import karaoke_audio_pkg::*;
#(
  parameter int PDM_DIV  = 8,
  parameter int R_LOG2   = 6,
  parameter int N_STAGES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pdm_data,
  output logic               pdm_clk,
  output logic signed [15:0] pcm_out,
  output logic               pcm_valid
);

  // Register width covers the full CIC gain R^N plus sign; must not exceed SAT_IN_W.
  localparam int W     = N_STAGES * R_LOG2 + 2;
  localparam int SHIFT = N_STAGES * R_LOG2 - 15;
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(N_STAGES);

  typedef logic signed [W-1:0] acc_t;

  logic pdm_bit;
  logic sample_stb;

  pdm_clkgen #(
    .PDM_DIV (PDM_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .pdm_data   (pdm_data),
    .pdm_clk    (pdm_clk),
    .pdm_bit    (pdm_bit),
    .sample_stb (sample_stb)
  );

  acc_t x_in;
  assign x_in = pdm_bit ? acc_t'(1) : acc_t'(-1);

  // Integrators wrap freely; the combs undo the wrap because the final result fits in W bits.
  genvar k;
  generate
    for (k = 0; k < N_STAGES; k++) begin : g_integ
      acc_t integ_q, integ_d;
      acc_t stage_in;

      if (k == 0) begin : g_first
        assign stage_in = x_in;
      end else begin : g_chain
        assign stage_in = g_integ[k-1].integ_q;
      end

      always_comb begin
        integ_d = integ_q;
        if (sample_stb) integ_d = integ_q + stage_in;
      end

      // NOTE: the integrators and comb delays are ordinary flops, not a RAM,
      // so they all take reset; stale history would corrupt the next outputs.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) integ_q <= '0;
        else          integ_q <= integ_d;
      end
    end
  endgenerate

  logic [R_LOG2-1:0] dec_cnt_q, dec_cnt_d;
  logic              dec_stb_q, dec_stb_d;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_stb_d = 1'b0;
    if (sample_stb) begin
      dec_cnt_d = dec_cnt_q + R_LOG2'(1);
      dec_stb_d = (dec_cnt_q == '1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_cnt_q <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      dec_stb_q <= dec_stb_d;
    end
  end

  // One comb per cycle; each stage's valid flag is the next stage's enable.
  generate
    for (k = 0; k < N_STAGES; k++) begin : g_comb
      acc_t comb_in;
      acc_t prev_q, prev_d;
      acc_t y_q, y_d;
      logic en;
      logic vld_q, vld_d;

      if (k == 0) begin : g_first
        assign comb_in = g_integ[N_STAGES-1].integ_q;
        assign en      = dec_stb_q;
      end else begin : g_chain
        assign comb_in = g_comb[k-1].y_q;
        assign en      = g_comb[k-1].vld_q;
      end

      always_comb begin
        prev_d = prev_q;
        y_d    = y_q;
        vld_d  = en;
        if (en) begin
          y_d    = comb_in - prev_q;
          prev_d = comb_in;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= '0;
          y_q    <= '0;
          vld_q  <= 1'b0;
        end else begin
          prev_q <= prev_d;
          y_q    <= y_d;
          vld_q  <= vld_d;
        end
      end
    end
  endgenerate

  acc_t comb_out;
  logic comb_vld;
  assign comb_out = g_comb[N_STAGES-1].y_q;
  assign comb_vld = g_comb[N_STAGES-1].vld_q;

  logic [WARM_W-1:0] warm_q, warm_d;
  logic              warm_done;
  pcm_t              pcm_out_q, pcm_out_d;
  logic              pcm_valid_q, pcm_valid_d;

  // Results completed during warm-up only advance the counter; pcm_out keeps its old value.
  always_comb begin
    warm_d      = warm_q;
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = 1'b0;
    warm_done   = (warm_q == WARM_DONE);
    if (comb_vld) begin
      if (warm_done) begin
        pcm_valid_d = 1'b1;
        pcm_out_d   = sat16(sat_in_t'(comb_out >>> SHIFT));
      end else begin
        warm_d = warm_q + WARM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q      <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      warm_q      <= warm_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: an FIR-form CIC model checks
// pdm_clk, pcm_valid and pcm_out every cycle; directed tests pin literals.
module tb_pdm_cic_decimator;

  localparam int PDM_DIV     = 8;
  localparam int R_LOG2      = 6;
  localparam int N_STAGES    = 4;
  localparam int R           = 1 << R_LOG2;
  localparam int L           = N_STAGES * (R - 1) + 1;
  localparam int SHIFT       = N_STAGES * R_LOG2 - 15;
  localparam int OUT_PERIOD  = PDM_DIV * R;
  localparam int LAT         = N_STAGES + 1;
  localparam int FIRST_VALID = (N_STAGES + 1) * OUT_PERIOD + LAT;
  localparam int WAIT_LIMIT  = FIRST_VALID + OUT_PERIOD;
  localparam int HIST        = 8192;

  typedef enum int {P_ONES, P_ZEROS, P_ALT, P_D75} pat_e;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               pdm_data = 1'b0;
  logic               pdm_clk;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   h [L];
  int   xhist [HIST];
  int   nbits = 0;
  pat_e mode = P_ONES;
  int   exp_out = 0;
  int   last_valid_cyc = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  pdm_cic_decimator #(
    .PDM_DIV  (PDM_DIV),
    .R_LOG2   (R_LOG2),
    .N_STAGES (N_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pdm_data  (pdm_data),
    .pdm_clk   (pdm_clk),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // CIC as its equivalent FIR: boxcar(R) convolved N times, with the N-1
  // sample delay of a registered integrator chain, decimated at sample R*k.
  function automatic int model_out(input int k);
    longint acc;
    int     idx;
    acc = 0;
    for (int i = 0; i < L; i++) begin
      idx = R * k - (N_STAGES - 1) - i;
      if (idx >= 1 && idx < HIST) acc += longint'(h[i]) * longint'(xhist[idx]);
    end
    acc = acc >>> SHIFT;
    if (acc > 32767)  return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  function automatic logic pick_bit(input pat_e m, input int n);
    case (m)
      P_ONES:  return 1'b1;
      P_ZEROS: return 1'b0;
      P_ALT:   return (n % 2 == 0);
      default: return (n % 4 != 3);
    endcase
  endfunction

  // Microphone: new bit shortly after each pdm_clk rise, stable through the low phase.
  initial begin
    logic b;
    forever begin
      @(posedge pdm_clk);
      #1;
      b = pick_bit(mode, nbits);
      pdm_data = b;
      nbits++;
      if (nbits < HIST) xhist[nbits] = b ? 1 : -1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic exp_clk;
    logic exp_valid;
    if (!reset_n) begin
      exp_out        = 0;
      last_valid_cyc = 0;
    end
    exp_clk   = (cyc != 0) && (((cyc - 1) % PDM_DIV) < PDM_DIV / 2);
    exp_valid = reset_n && (cyc >= FIRST_VALID) && (cyc % OUT_PERIOD == LAT);
    if (exp_valid) exp_out = model_out((cyc - LAT) / OUT_PERIOD);
    check("pdm_clk", pdm_clk, exp_clk);
    check("pcm_valid", pcm_valid, exp_valid);
    check("pcm_out", pcm_out, exp_out);
    if (pcm_valid) begin
      check("valid_consec", prev_valid, 0);
      if (last_valid_cyc != 0) check("valid_spacing", cyc - last_valid_cyc, OUT_PERIOD);
      last_valid_cyc = cyc;
    end
    prev_valid = pcm_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    nbits = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int n = 0; n < WAIT_LIMIT; n++) begin
      @(negedge clk);
      if (pcm_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: no pcm_valid within %0d cycles, expected one", WAIT_LIMIT);
    end
  endtask

  initial begin
    int at;
    int len;
    int hsum;
    int tmp [L];

    #1 reset_n = 1'b0;

    for (int i = 0; i < L; i++) h[i] = (i < R) ? 1 : 0;
    len = R;
    for (int s = 1; s < N_STAGES; s++) begin
      for (int i = 0; i < L; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      h = tmp;
      len += R - 1;
    end
    hsum = 0;
    for (int i = 0; i < L; i++) hsum += h[i];
    check("model_gain", hsum, 16777216);
    check("model_h_first", h[0], 1);

    // All ones: full-scale positive clamps to 32767.
    mode = P_ONES;
    do_reset();
    wait_valid(at);
    check("ones_first_valid_cyc", at, 2565);
    check("ones_level", pcm_out, 32767);
    repeat (3) begin
      wait_valid(at);
      check("ones_level", pcm_out, 32767);
    end

    // All zeros: integrators overflow but the output is exactly -32768.
    mode = P_ZEROS;
    do_reset();
    wait_valid(at);
    check("zeros_first_valid_cyc", at, 2565);
    check("zeros_level", pcm_out, -32768);
    repeat (3) begin
      wait_valid(at);
      check("zeros_level", pcm_out, -32768);
    end

    // Alternating bits: zero mean lands in a boxcar null.
    mode = P_ALT;
    do_reset();
    repeat (3) begin
      wait_valid(at);
      check("alt_level", pcm_out, 0);
    end

    // Reset two cycles after a decimation strobe kills the in-flight result.
    mode = P_ONES;
    do_reset();
    wait_valid(at);
    check("rstmid_pre_level", pcm_out, 32767);
    repeat (OUT_PERIOD - LAT + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    nbits = 0;
    repeat (3) @(negedge clk);
    check("rstmid_out_in_reset", pcm_out, 0);
    check("rstmid_valid_in_reset", pcm_valid, 0);
    #2 reset_n = 1'b1;
    repeat (FIRST_VALID - 1) @(negedge clk);
    check("rstmid_out_before_warm", pcm_out, 0);
    wait_valid(at);
    check("rstmid_first_valid_cyc", at, 2565);
    check("rstmid_level", pcm_out, 32767);

    // Density step from all zeros to 75 % ones settles at 16384.
    mode = P_ZEROS;
    do_reset();
    repeat (2) wait_valid(at);
    check("step_pre_level", pcm_out, -32768);
    mode = P_D75;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(at);
      if (i == 4) check("d75_settle4", (pcm_out >= 16383 && pcm_out <= 16385), 1);
      if (i >= 5) check("d75_level", pcm_out, 16384);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
